// File: rtl/polar_encoder_pkg.sv
// Shared constants and helpers for the multilevel-PPM polar code (N=256).
// Also holds the 106-bit information-set mask used by encoder and decoder.
package pkg_mlpolar;

  localparam int N = 256;
  localparam int LOG2N = 8;
  localparam int K_DESIGN = 106;

  function automatic logic [LOG2N-1:0] bitrev_idx(
    input logic [LOG2N-1:0] i
  );
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) begin
      r[b] = i[LOG2N-1-b];
    end
    return r;
  endfunction

  function automatic int count_zeros(input logic [N-1:0] m);
    int c;
    c = 0;
    for (int i = 0; i < N; i++) begin
      if (!m[i]) c++;
    end
    return c;
  endfunction

  // RM-like information set: every index of weight >= 5,
  // topped up with the highest-valued weight-4 indices.
  function automatic logic [N-1:0] design_frozen();
    logic [N-1:0] m;
    int w;
    int w4;
    m = '1;
    w4 = 0;
    for (int i = N - 1; i >= 0; i--) begin
      w = $countones(i[LOG2N-1:0]);
      if (w >= 5) begin
        m[i] = 1'b0;
      end else if (w == 4 && w4 < K_DESIGN - 93) begin
        m[i] = 1'b0;
        w4++;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/polar_encoder_butterfly.sv
// One polar transform stage: u[j] ^= u[j + 2^s] wherever bit s of j is 0.
// Purely combinational; all eight stages are built and the live one muxed out.
module polar_butterfly_stage
  import pkg_mlpolar::*;
(
  input  logic [N-1:0] u_i,
  input  logic [2:0]   stage_i,
  output logic [N-1:0] u_o
);

  logic [LOG2N-1:0][N-1:0] res;

  for (genvar s = 0; s < LOG2N; s++) begin : g_s
    for (genvar j = 0; j < N; j++) begin : g_j
      if (((j >> s) & 1) == 0) begin : g_x
        assign res[s][j] = u_i[j] ^ u_i[j + (1 << s)];
      end else begin : g_p
        assign res[s][j] = u_i[j];
      end
    end
  end

  assign u_o = res[stage_i];

endmodule

// File: rtl/polar_encoder.sv
// N=256 polar encoder: serial info load, 8-cycle in-place transform, stream out.
// Define POLAR_ENC_BITREV_EN to emit coded bits in bit-reversed index order.
module polar_encoder
  import pkg_mlpolar::*;
#(
  parameter logic [N-1:0] FROZEN   = design_frozen(),
  parameter int           K_INFO_P = 106
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enc_start,
  input  logic info_valid,
  input  logic info_bit,
  output logic info_ready,
  output logic cw_valid,
  output logic cw_bit,
  output logic cw_last,
  input  logic cw_ready,
  output logic enc_done,
  output logic busy
);

  if (count_zeros(FROZEN) != K_INFO_P) begin : g_k_chk
    $error("K_INFO_P differs from zero count of FROZEN");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ENCODE,
    ST_EMIT
  } enc_state_t;

  enc_state_t state_q, state_d;
  logic [N-1:0] u_q, u_d, u_bfly;
  logic [LOG2N-1:0] ptr_q, ptr_d;
  logic [LOG2N-1:0] idx_q, idx_d, map_idx;
  logic [2:0] stage_q, stage_d;
  logic done_q, done_d;
  logic adv;

  polar_butterfly_stage u_bfly_stage (
    .u_i     (u_q),
    .stage_i (stage_q),
    .u_o     (u_bfly)
  );

`ifdef POLAR_ENC_BITREV_EN
  assign map_idx = bitrev_idx(idx_q);
`else
  assign map_idx = idx_q;
`endif

  assign busy       = state_q != ST_IDLE;
  assign info_ready = (state_q == ST_LOAD)
                    && !FROZEN[ptr_q];
  assign adv        = FROZEN[ptr_q]
                    || (info_valid && info_ready);
  assign cw_valid   = state_q == ST_EMIT;
  assign cw_bit     = cw_valid && u_q[map_idx];
  assign cw_last    = cw_valid && (&idx_q);
  assign enc_done   = done_q;

  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    ptr_d   = ptr_q;
    stage_d = stage_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        u_d   = '0;
        ptr_d = '0;
        if (enc_start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (adv) begin
          u_d[ptr_q] = !FROZEN[ptr_q] && info_bit;
          ptr_d      = ptr_q + 1'b1;
          if (&ptr_q) begin
            state_d = ST_ENCODE;
            stage_d = '0;
          end
        end
      end
      ST_ENCODE: begin
        u_d     = u_bfly;
        stage_d = stage_q + 1'b1;
        if (&stage_q) begin
          state_d = ST_EMIT;
          idx_d   = '0;
        end
      end
      ST_EMIT: begin
        if (cw_ready) begin
          idx_d = idx_q + 1'b1;
          if (&idx_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      u_q     <= '0;
      ptr_q   <= '0;
      stage_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      ptr_q   <= ptr_d;
      stage_q <= stage_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_polar_encoder.sv
// Bench for polar_encoder: four frozen-set variants against a u*G model.
// Honours POLAR_ENC_BITREV_EN for the expected output order.
module tb_polar_encoder;
  import pkg_mlpolar::*;

  logic clk;
  logic rst_n;
  logic [3:0] st, iv, ib, cr;
  logic [3:0] ir, cv, cb, cl, dn, bz;

  logic [N-1:0] fro [4];
  int kk [4];
  logic [N-1:0] info [4];
  logic [N-1:0] expw [4];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  polar_encoder #(.FROZEN({N{1'b1}}), .K_INFO_P(0)) d0 (
    .clk(clk), .rst_n(rst_n), .enc_start(st[0]),
    .info_valid(iv[0]), .info_bit(ib[0]),
    .info_ready(ir[0]), .cw_valid(cv[0]), .cw_bit(cb[0]),
    .cw_last(cl[0]), .cw_ready(cr[0]), .enc_done(dn[0]),
    .busy(bz[0]));

  polar_encoder #(.FROZEN(~(256'b1 << 255)), .K_INFO_P(1)) d1 (
    .clk(clk), .rst_n(rst_n), .enc_start(st[1]),
    .info_valid(iv[1]), .info_bit(ib[1]),
    .info_ready(ir[1]), .cw_valid(cv[1]), .cw_bit(cb[1]),
    .cw_last(cl[1]), .cw_ready(cr[1]), .enc_done(dn[1]),
    .busy(bz[1]));

  polar_encoder #(.FROZEN(~256'b1), .K_INFO_P(1)) d2 (
    .clk(clk), .rst_n(rst_n), .enc_start(st[2]),
    .info_valid(iv[2]), .info_bit(ib[2]),
    .info_ready(ir[2]), .cw_valid(cv[2]), .cw_bit(cb[2]),
    .cw_last(cl[2]), .cw_ready(cr[2]), .enc_done(dn[2]),
    .busy(bz[2]));

  polar_encoder d3 (
    .clk(clk), .rst_n(rst_n), .enc_start(st[3]),
    .info_valid(iv[3]), .info_bit(ib[3]),
    .info_ready(ir[3]), .cw_valid(cv[3]), .cw_bit(cb[3]),
    .cw_last(cl[3]), .cw_ready(cr[3]), .enc_done(dn[3]),
    .busy(bz[3]));

  task automatic chk(input string nm, input int k,
                     input int act, input int want);
    checks++;
    if (act != want) begin
      failures++;
      $display("FAIL %s dut%0d: got %0d want %0d",
               nm, k, act, want);
    end
  endtask

  task automatic chkv(input string nm,
                      input logic [N-1:0] act,
                      input logic [N-1:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  function automatic int brv(input int t);
`ifdef POLAR_ENC_BITREV_EN
    int r = 0;
    for (int b = 0; b < LOG2N; b++) begin
      if (t[b]) r |= 1 << (LOG2N - 1 - b);
    end
    return r;
`else
    return t;
`endif
  endfunction

  // x[j] is the XOR of every u[i] whose index bits contain j's bits.
  function automatic logic [N-1:0] stream(
    input logic [N-1:0] fz, input logic [N-1:0] inf);
    logic [N-1:0] u = '0, x = '0, s = '0;
    int n = 0;
    for (int i = 0; i < N; i++) begin
      if (!fz[i]) begin
        u[i] = inf[n];
        n++;
      end
    end
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) begin
        if ((i & j) == j) x[j] ^= u[i];
      end
    end
    for (int t = 0; t < N; t++) s[t] = x[brv(t)];
    return s;
  endfunction

  function automatic int trail(input logic [N-1:0] fz);
    int t = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!fz[i]) break;
      t++;
    end
    return t;
  endfunction

  int ex_idx [4], acc [4], st_cyc [4], lacc [4];
  bit pend [4], stl [4], seen [4];
  logic pcb [4], pcl [4];

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst_n) begin
        chk("reset_outputs", k,
            int'({ir[k], cv[k], cb[k], cl[k], dn[k], bz[k]}), 0);
        ex_idx[k] = 0; acc[k] = 0; pend[k] = 0;
        stl[k] = 0; seen[k] = 0;
      end else begin
        if (dn[k] || pend[k]) begin
          chk("enc_done", k, int'(dn[k]), int'(pend[k]));
          chk("busy_at_done", k, int'(bz[k]), 0);
        end
        pend[k] = 0;
        if (!bz[k])
          chk("idle_outputs", k,
              int'({ir[k], cv[k], cl[k]}), 0);
        if (st[k] && !bz[k]) begin
          ex_idx[k] = 0; acc[k] = 0; seen[k] = 0;
          st_cyc[k] = cyc + 1;
        end
        if (ir[k])
          chk("info_ready_legal", k,
              int'(bz[k] && acc[k] < kk[k]), 1);
        if (iv[k] && ir[k]) begin
          acc[k]++;
          lacc[k] = cyc + 1;
        end
        if (stl[k])
          chk("stall_hold", k,
              int'({cv[k], cb[k], cl[k]}),
              int'({1'b1, pcb[k], pcl[k]}));
        if (cv[k] && !seen[k]) begin
          seen[k] = 1;
          chk("latency", k, cyc - ((kk[k] == 0) ?
              st_cyc[k] + N : lacc[k] + trail(fro[k])), 8);
        end
        if (cv[k] && cr[k]) begin
          if (ex_idx[k] < N) begin
            chk("cw_bit", k, int'(cb[k]),
                int'(expw[k][ex_idx[k]]));
            chk("cw_last", k, int'(cl[k]),
                int'(ex_idx[k] == N - 1));
            pend[k] = (ex_idx[k] == N - 1);
          end else begin
            chk("extra_transfer", k, ex_idx[k], N - 1);
          end
          ex_idx[k]++;
        end
        stl[k] = cv[k] && !cr[k];
        pcb[k] = cb[k];
        pcl[k] = cl[k];
      end
    end
  end

  task automatic run(input int k, input int gap,
                     input int duty, input int rst_at,
                     input int stp_at);
    int n = 0, xf_n = 0, t = 0;
    bit a, xf, fin = 0;
    expw[k] = stream(fro[k], info[k]);
    @(posedge clk); #1;
    st[k] = 1'b1;
    @(posedge clk); #1;
    st[k] = 1'b0;
    while (!fin) begin
      iv[k] = (n >= kk[k]) ? 1'b1
            : ($urandom_range(99) >= gap);
      ib[k] = (n < kk[k]) ? info[k][n] : 1'($urandom);
      cr[k] = ($urandom_range(99) < duty);
      st[k] = (xf_n == stp_at);
      @(negedge clk);
      a  = iv[k] & ir[k];
      xf = cv[k] & cr[k];
      if (dn[k]) fin = 1;
      @(posedge clk); #1;
      if (a) n++;
      if (xf) xf_n++;
      if (rst_at >= 0 && xf_n == rst_at) begin
        rst_n = 1'b0;
        fin = 1;
      end
      t++;
      if (t > 20000 && !fin) begin
        chk("timeout", k, t, 0);
        fin = 1;
      end
    end
    st[k] = 1'b0; iv[k] = 1'b0; cr[k] = 1'b0;
  endtask

  initial begin
    logic [N-1:0] m;
    logic [N-1:0] one;
    logic [N-1:0] want;
    rst_n = 1'b0;
    st = '0; iv = '0; ib = '0; cr = '0;
    fro[0] = '1;              kk[0] = 0;
    fro[1] = ~(256'b1 << 255); kk[1] = 1;
    fro[2] = ~256'b1;         kk[2] = 1;
    fro[3] = design_frozen(); kk[3] = 106;
    for (int k = 0; k < 4; k++) begin
      info[k] = '0;
      expw[k] = '0;
    end
    one = 256'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chkv("model_last_only", stream(fro[1], one), '1);
    chkv("model_first_only", stream(fro[2], one), 256'b1);
    chkv("model_all_frozen", stream(fro[0], '1), '0);
    m = '1;
    m[1] = 1'b0;
`ifdef POLAR_ENC_BITREV_EN
    want = (256'b1 << 128) | 256'b1;
`else
    want = 256'h3;
`endif
    chkv("model_pos1_only", stream(m, one), want);
    chk("design_k", 0, N - $countones(fro[3]), 106);

    run(0, 0, 100, -1, 50);
    info[1] = one;
    run(1, 0, 100, -1, -1);
    info[2] = one;
    run(2, 30, 70, -1, 10);
    for (int i = 0; i < 106; i++) info[3][i] = 1'($urandom);
    run(3, 0, 100, -1, -1);
    run(3, 40, 30, -1, 77);
    run(3, 0, 100, 100, -1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 106; i++) info[3][i] = 1'($urandom);
    run(3, 20, 50, -1, -1);
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
